// File: rtl/l2_evict_write_buffer.sv
// -----------------------------------------------------------------------------
// l2_evict_write_buffer
//
// Eviction write buffer between the L2 controller's physical-memory port and
// physical memory. Dirty-line writebacks from L2 complete in the cycle they are
// presented. The line is parked in a small circular FIFO and drained to memory
// whenever the L2 port is idle. L2 line reads are forwarded to memory. They are
// kept coherent with the parked lines either by draining first (default) or by
// serving hits directly from the buffer (EWB_READ_FWD_EN).
//
// Optional feature macro: EWB_READ_FWD_EN
//   defined   : L2 reads that hit a buffered line return it immediately; misses
//               go straight to memory even if lines remain buffered.
//   undefined : L2 reads first drain the whole buffer, then go to memory.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   l2_pmem_read      L2 line read request (held until l2_pmem_resp)
//   l2_pmem_write     L2 writeback request (held until l2_pmem_resp)
//   l2_pmem_address   L2 request address (offset bits ignored)
//   l2_pmem_wdata     writeback line
//   l2_pmem_rdata     read line to L2, valid with l2_pmem_resp
//   l2_pmem_resp      one-cycle completion pulse to L2
//   ewb_stall         L2 must not start a new miss sequence
//   pmem_read/write   memory requests (never both high)
//   pmem_address      line-aligned memory address
//   pmem_wdata        drained line
//   pmem_rdata        memory read data
//   pmem_resp         memory completion
// -----------------------------------------------------------------------------
module l2_evict_write_buffer #(
  parameter int DEPTH    = 2,
  parameter int LINE_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l2_pmem_read,
  input  logic              l2_pmem_write,
  input  logic [ADDR_W-1:0] l2_pmem_address,
  input  logic [LINE_W-1:0] l2_pmem_wdata,
  output logic [LINE_W-1:0] l2_pmem_rdata,
  output logic              l2_pmem_resp,
  output logic              ewb_stall,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_FWD = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count;
  logic [TAG_W-1:0]  rd_tag_q;

  logic [TAG_W-1:0]  req_tag;
  logic              hit;
  logic [PTR_W-1:0]  hit_idx;
  logic              full, empty;

  logic              do_push, do_coalesce, do_pop, load_rd_tag;
  logic              resp_c;
  logic [LINE_W-1:0] rdata_c;

  // The offset bits of the L2 address carry no meaning for a line buffer.
  logic unused_offset;
  assign unused_offset = ^l2_pmem_address[OFFSET_W-1:0];

  assign req_tag = l2_pmem_address[ADDR_W-1:OFFSET_W];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // Tags in the buffer are unique because every write to a buffered line
  // coalesces, so at most one entry can match.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    do_push      = 1'b0;
    do_coalesce  = 1'b0;
    do_pop       = 1'b0;
    load_rd_tag  = 1'b0;
    resp_c       = 1'b0;
    rdata_c      = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        // A simultaneous read and write is illegal from L2; the write wins.
        if (l2_pmem_write) begin
          if (hit) begin
            do_coalesce = 1'b1;
            resp_c      = 1'b1;
          end else if (!full) begin
            do_push = 1'b1;
            resp_c  = 1'b1;
          end
        end else if (l2_pmem_read) begin
`ifdef EWB_READ_FWD_EN
          if (hit) begin
            resp_c  = 1'b1;
            rdata_c = data_q[hit_idx];
          end else begin
            state_d     = RD_FWD;
            load_rd_tag = 1'b1;
          end
`else
          // Memory must hold every buffered line before the read is issued.
          if (!empty) begin
            state_d = DRAIN;
          end else begin
            state_d     = RD_FWD;
            load_rd_tag = 1'b1;
          end
`endif
        end else if (!empty) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Head does not move until pmem_resp, so these stay stable.
        pmem_write   = 1'b1;
        pmem_address = {tag_q[head_q], {OFFSET_W{1'b0}}};
        pmem_wdata   = data_q[head_q];
        if (pmem_resp) begin
          do_pop  = 1'b1;
          state_d = IDLE;
        end
      end

      RD_FWD: begin
        pmem_read    = 1'b1;
        pmem_address = {rd_tag_q, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          resp_c  = 1'b1;
          rdata_c = pmem_rdata;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // L2 may be holding a request while reset is asserted; keep the response
  // path quiet so every output reads zero during reset.
  assign l2_pmem_resp  = rst_n & resp_c;
  assign l2_pmem_rdata = rst_n ? rdata_c : '0;
  assign ewb_stall     = full | (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count    <= '0;
      rd_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_rd_tag) rd_tag_q <= req_tag;
      // Push happens only in IDLE and pop only in DRAIN, never together.
      if (do_push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
        count           <= count + CNT_W'(1);
      end
      if (do_pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
        count           <= count - CNT_W'(1);
      end
    end
  end

  // NOTE: tag/data storage has no reset; an entry is only ever looked at
  // while its valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_q[tail_q]  <= req_tag;
      data_q[tail_q] <= l2_pmem_wdata;
    end else if (do_coalesce) begin
      data_q[hit_idx] <= l2_pmem_wdata;
    end
  end

endmodule

// File: tb/tb_l2_evict_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_l2_evict_write_buffer
//
// Directed bench for l2_evict_write_buffer (DEPTH=2, 256-bit lines) with a
// behavioural memory that answers every request after a fixed latency, plus a
// short burst of random L2 traffic checked against a reference line image.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_l2_evict_write_buffer;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam int LAT    = 3;
  localparam int NLINES = 8;

  logic              clk;
  logic              rst_n;
  logic              l2_pmem_read;
  logic              l2_pmem_write;
  logic [ADDR_W-1:0] l2_pmem_address;
  logic [LINE_W-1:0] l2_pmem_wdata;
  logic [LINE_W-1:0] l2_pmem_rdata;
  logic              l2_pmem_resp;
  logic              ewb_stall;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  l2_evict_write_buffer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .l2_pmem_read    (l2_pmem_read),
    .l2_pmem_write   (l2_pmem_write),
    .l2_pmem_address (l2_pmem_address),
    .l2_pmem_wdata   (l2_pmem_wdata),
    .l2_pmem_rdata   (l2_pmem_rdata),
    .l2_pmem_resp    (l2_pmem_resp),
    .ewb_stall       (ewb_stall),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  logic [LINE_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] ref_line [NLINES];

  localparam logic [LINE_W-1:0] D1  = {8{32'hD1D1_0001}};
  localparam logic [LINE_W-1:0] D2  = {8{32'hD2D2_0002}};
  localparam logic [LINE_W-1:0] D2B = {8{32'hD2D2_B00B}};
  localparam logic [LINE_W-1:0] D2C = {8{32'hD2D2_C00C}};
  localparam logic [LINE_W-1:0] D3  = {8{32'hD3D3_0003}};
  localparam logic [LINE_W-1:0] D4  = {8{32'hD4D4_0004}};
  localparam logic [LINE_W-1:0] D5  = {8{32'hD5D5_0005}};
  localparam logic [LINE_W-1:0] D6  = {8{32'hD6D6_0006}};

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Behavioural memory: answers any request after LAT cycles with a
  // one-cycle pmem_resp; a write commits when its response is given.
  initial begin
    int cnt;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pmem_resp = 1'b0;
        cnt       = 0;
      end else if (pmem_resp) begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        cnt        = 0;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt >= LAT) begin
          pmem_resp = 1'b1;
          if (pmem_write) mem[pmem_address] = pmem_wdata;
          else            pmem_rdata = mem_rd(pmem_address);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && pmem_read && pmem_write) overlap++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // One L2 transaction: waits for ewb_stall low, raises the request, holds
  // it until l2_pmem_resp and drops it after the completing edge.
  task automatic l2_req(input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [LINE_W-1:0] d,
                        output logic [LINE_W-1:0] rd, output bit got);
    got = 1'b0;
    rd  = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (!ewb_stall) break;
      @(posedge clk);
      #1;
    end
    l2_pmem_write   = wr;
    l2_pmem_read    = !wr;
    l2_pmem_address = a;
    l2_pmem_wdata   = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (l2_pmem_resp) begin
        got = 1'b1;
        rd  = l2_pmem_rdata;
      end
      @(posedge clk);
      #1;
      if (got) break;
    end
    l2_pmem_write = 1'b0;
    l2_pmem_read  = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dut.count == 0 && !ewb_stall) break;
    end
    check(tag, {255'd0, (dut.count == 0)}, 256'd1);
  endtask

  initial begin
    logic [LINE_W-1:0] rd;
    bit                got;
    bit                saw_read, order_bad, seen;

    rst_n           = 1'b0;
    l2_pmem_read    = 1'b0;
    l2_pmem_write   = 1'b0;
    l2_pmem_address = '0;
    l2_pmem_wdata   = '0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_resp",  l2_pmem_resp, 0);
    check("rst_stall", ewb_stall, 0);
    check("rst_pmw",   pmem_write, 0);
    check("rst_pmr",   pmem_read, 0);
    check("rst_addr",  pmem_address, 0);
    rst_n = 1'b1;

    // ---- single write then drain ----
    @(posedge clk); #1;
    l2_pmem_write   = 1'b1;
    l2_pmem_address = 32'h0000_1020;
    l2_pmem_wdata   = D1;
    @(negedge clk);
    check("t1_resp", l2_pmem_resp, 1);
    check("t1_pmw_busy", pmem_write, 0);
    @(posedge clk); #1;
    l2_pmem_write = 1'b0;
    @(negedge clk);
    check("t1_count", dut.count, 1);
    check("t1_resp_drop", l2_pmem_resp, 0);
    @(negedge clk);
    check("t1_pmw", pmem_write, 1);
    check("t1_paddr", pmem_address, 32'h0000_1020);
    check("t1_pwdata", pmem_wdata, D1);
    check("t1_stall", ewb_stall, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!pmem_write) break;
    end
    check("t1_drained", pmem_write, 0);
    check("t1_count0", dut.count, 0);
    check("t1_stall0", ewb_stall, 0);
    check("t1_mem", mem_rd(32'h0000_1020), D1);

    // ---- fill, full-block, coalesce when full ----
    @(posedge clk); #1;
    l2_pmem_write   = 1'b1;
    l2_pmem_address = 32'h0000_0100;
    l2_pmem_wdata   = D2;
    @(negedge clk);
    check("t2_resp_a", l2_pmem_resp, 1);
    @(posedge clk); #1;
    l2_pmem_address = 32'h0000_0200;
    l2_pmem_wdata   = D2B;
    @(negedge clk);
    check("t2_resp_b", l2_pmem_resp, 1);
    @(posedge clk); #1;
    l2_pmem_address = 32'h0000_0300;
    l2_pmem_wdata   = D2C;
    @(negedge clk);
    check("t2_full_noresp", l2_pmem_resp, 0);
    check("t2_full_stall", ewb_stall, 1);
    check("t2_full_count", dut.count, 2);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_full_noresp2", l2_pmem_resp, 0);
    check("t2_no_drain", pmem_write, 0);
    @(posedge clk); #1;
    l2_pmem_address = 32'h0000_0100;
    l2_pmem_wdata   = D3;
    @(negedge clk);
    check("t2_coal_resp", l2_pmem_resp, 1);
    @(posedge clk); #1;
    l2_pmem_write = 1'b0;
    @(negedge clk);
    check("t2_coal_count", dut.count, 2);
    wait_empty("t2_empty");
    check("t2_mem_100", mem_rd(32'h0000_0100), D3);
    check("t2_mem_200", mem_rd(32'h0000_0200), D2B);
    check("t2_mem_300", mem_rd(32'h0000_0300), 0);

    // ---- read handling with a buffered line ----
    mem[32'h0000_0800] = D5;
    @(posedge clk); #1;
    l2_pmem_write   = 1'b1;
    l2_pmem_address = 32'h0000_0400;
    l2_pmem_wdata   = D4;
    @(negedge clk);
    check("t3_wr_resp", l2_pmem_resp, 1);
`ifdef EWB_READ_FWD_EN
    @(posedge clk); #1;
    l2_pmem_write   = 1'b0;
    l2_pmem_read    = 1'b1;
    l2_pmem_address = 32'h0000_041C;
    @(negedge clk);
    check("t3_hit_resp", l2_pmem_resp, 1);
    check("t3_hit_rdata", l2_pmem_rdata, D4);
    check("t3_hit_pmr", pmem_read, 0);
    @(posedge clk); #1;
    l2_pmem_read = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
      if (dut.count == 0 && !ewb_stall) break;
    end
    check("t3_no_pmem_read", {255'd0, seen}, 0);
    check("t3_mem_400", mem_rd(32'h0000_0400), D4);
`else
    @(posedge clk); #1;
    l2_pmem_write   = 1'b0;
    l2_pmem_read    = 1'b1;
    l2_pmem_address = 32'h0000_0800;
    @(negedge clk);
    check("t3_rd_noresp", l2_pmem_resp, 0);
    @(negedge clk);
    check("t3_drain_first", pmem_write, 1);
    check("t3_drain_addr", pmem_address, 32'h0000_0400);
    check("t3_drain_nord", pmem_read, 0);
    saw_read  = 1'b0;
    order_bad = 1'b0;
    got       = 1'b0;
    rd        = '0;
    for (int i = 0; i < 60; i++) begin
      if (pmem_read) saw_read = 1'b1;
      if (pmem_write && saw_read) order_bad = 1'b1;
      if (l2_pmem_resp) begin
        got = 1'b1;
        rd  = l2_pmem_rdata;
        break;
      end
      @(negedge clk);
    end
    check("t3_rd_got", {255'd0, got}, 1);
    check("t3_rd_seen", {255'd0, saw_read}, 1);
    check("t3_order", {255'd0, order_bad}, 0);
    check("t3_rdata", rd, D5);
    check("t3_mem_400", mem_rd(32'h0000_0400), D4);
    @(posedge clk); #1;
    l2_pmem_read = 1'b0;
    @(negedge clk);
    check("t3_resp_drop", l2_pmem_resp, 0);
`endif

    // ---- reset in the middle of a drain ----
    @(posedge clk); #1;
    l2_pmem_write   = 1'b1;
    l2_pmem_address = 32'h0000_0500;
    l2_pmem_wdata   = D6;
    @(negedge clk);
    check("t4_wr_resp", l2_pmem_resp, 1);
    @(posedge clk); #1;
    l2_pmem_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pmem_write) break;
    end
    check("t4_in_drain", pmem_write, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_rst_pmw", pmem_write, 0);
    check("t4_rst_stall", ewb_stall, 0);
    check("t4_rst_addr", pmem_address, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_count", dut.count, 0);
    check("t4_idle_pmw", pmem_write, 0);
    check("t4_idle_stall", ewb_stall, 0);
    check("t4_lost", mem_rd(32'h0000_0500), 0);

    // ---- random traffic against the reference image ----
    for (int k = 0; k < NLINES; k++) begin
      ref_line[k] = {8{32'hA5A5_0000 | 32'(k)}};
      mem[32'h0000_2000 + 32'(k * 32)] = ref_line[k];
    end
    for (int n = 0; n < 60; n++) begin
      int               k;
      bit               wr;
      logic [ADDR_W-1:0] a;
      logic [LINE_W-1:0] d;
      k  = int'($urandom_range(NLINES - 1, 0));
      wr = ($urandom_range(1, 0) == 1);
      a  = 32'h0000_2000 + 32'(k * 32) + 32'($urandom_range(31, 0));
      d  = rand_line();
      l2_req(wr, a, d, rd, got);
      check($sformatf("rnd%0d_got", n), {255'd0, got}, 1);
      if (wr) ref_line[k] = d;
      else    check($sformatf("rnd%0d_rdata", n), rd, ref_line[k]);
    end
    wait_empty("rnd_empty");
    check("rnd_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
